// File: rtl/imem_tap_sequencer_if.sv
// Signal bundle between the FIR tap sequencer, the filter control, the imem
// read mux and the MAC datapath.
`timescale 1ns/1ps
interface imem_tap_sequencer_if #(
  parameter int n    = 16,
  parameter int logn = 4
);
  logic            start;
  logic            abort;
  logic [logn-1:0] tap_last;
  logic [logn-1:0] sel;
  logic [n-1:0]    mux_data;
  logic [n-1:0]    coef_out;
  logic            coef_valid;
  logic            coef_ready;
  logic            coef_last;
  logic            busy;
  logic            done;

  modport master (
    input  start, abort, tap_last, mux_data, coef_ready,
    output sel, coef_out, coef_valid, coef_last, busy, done
  );

  modport slave (
    output start, abort, tap_last, mux_data, coef_ready,
    input  sel, coef_out, coef_valid, coef_last, busy, done
  );
endinterface

// File: rtl/imem_tap_sequencer.sv
// Walks the 16-entry FIR coefficient memory through an external mux and hands
// each captured word to the MAC over a valid/ready handshake.
`timescale 1ns/1ps
module imem_tap_sequencer #(
  parameter int n    = 16,
  parameter int logn = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_tap_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t          state_q, state_d;
  logic [logn-1:0] sel_q, sel_d;
  logic [logn-1:0] last_q, last_d;
  logic [n-1:0]    coef_q, coef_d;
  logic            valid_q, valid_d;
  logic            clast_q, clast_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= '0;
      coef_q  <= '0;
      valid_q <= 1'b0;
      clast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      coef_q  <= coef_d;
      valid_q <= valid_d;
      clast_q <= clast_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    coef_d  = coef_q;
    valid_d = valid_q;
    clast_d = clast_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Abort outranks both the handshake and START; it never produces DONE.
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      sel_d   = '0;
      valid_d = 1'b0;
      clast_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            last_d  = bus.tap_last;
            sel_d   = '0;
            busy_d  = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: begin
          coef_d  = bus.mux_data;
          valid_d = 1'b1;
          clast_d = (sel_q == last_q);
          state_d = SEND;
        end
        SEND: begin
          if (bus.coef_ready) begin
            valid_d = 1'b0;
            if (clast_q) begin
              clast_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              sel_d   = '0;
              state_d = IDLE;
            end else begin
              sel_d   = sel_q + logn'(1);
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.coef_out   = coef_q;
  assign bus.coef_valid = valid_q;
  assign bus.coef_last  = clast_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_imem_tap_sequencer.sv
// Randomized directed bench for imem_tap_sequencer: a per-sweep word/stall
// model predicts every beat, the last flag, DONE timing and abort/reset effects.
`timescale 1ns/1ps
module tb_imem_tap_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] base;
  logic [15:0] junk;
  bit          junk_en;

  imem_tap_sequencer_if #(.n(16), .logn(4)) bus ();

  imem_tap_sequencer #(.n(16), .logn(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Mux returns base+sel only while the bench expects a capture; junk otherwise.
  assign bus.mux_data = junk_en ? junk : (base + {12'b0, bus.sel});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk({tag, "_done"}, 32'(bus.done), 32'(0));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
      chk({tag, "_valid"}, 32'(bus.coef_valid), 32'(0));
    end
  endtask

  task automatic do_abort();
    bus.abort      = 1'b1;
    bus.coef_ready = 1'b1;
    @(posedge clk); #1;
    bus.abort      = 1'b0;
    bus.coef_ready = 1'b0;
    chk("abort_valid", 32'(bus.coef_valid), 32'(0));
    chk("abort_last", 32'(bus.coef_last), 32'(0));
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_sel", 32'(bus.sel), 32'(0));
    chk("abort_done", 32'(bus.done), 32'(0));
    idle_checks("post_abort", 3);
  endtask

  task automatic do_reset();
    bus.coef_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(bus.sel), 32'(0));
    chk("arst_valid", 32'(bus.coef_valid), 32'(0));
    chk("arst_last", 32'(bus.coef_last), 32'(0));
    chk("arst_busy", 32'(bus.busy), 32'(0));
    chk("arst_done", 32'(bus.done), 32'(0));
    chk("arst_coef", 32'(bus.coef_out), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_checks("post_reset", 3);
  endtask

  // One sweep of taps 0..tl. Word k is b+k; each READY=0 beat in SEND adds a cycle.
  task automatic sweep(input logic [3:0] tl, input logic [15:0] b, input int stall_pct,
                       input int abort_k, input int rst_k, input bit mess,
                       input bit chain, input logic [3:0] chain_tl, input bit prestarted);
    int k      = 0;
    int stalls = 0;
    int e      = 0;
    bit fetch  = 1'b1;
    bit fin    = 1'b0;
    bit rdy;
    base    = b;
    junk_en = 1'b1;
    junk    = 16'($urandom);
    if (!prestarted) begin
      bus.start    = 1'b1;
      bus.tap_last = tl;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!fin && e < 400) begin
      chk("valid", 32'(bus.coef_valid), 32'(!fetch));
      chk("busy", 32'(bus.busy), 32'(1));
      chk("done_low", 32'(bus.done), 32'(0));
      chk("sel", 32'(bus.sel), 32'(k));
      if (bus.coef_valid) begin
        chk("word", 32'(bus.coef_out), 32'(16'(b + 16'(k))));
        chk("last_flag", 32'(bus.coef_last), 32'(k == int'(tl)));
      end
      if (fetch) begin
        junk_en        = 1'b0;
        fetch          = 1'b0;
        bus.start      = 1'b0;
        bus.coef_ready = 1'($urandom);
        @(posedge clk); #1;
        e++;
      end else begin
        junk_en = 1'b1;
        junk    = 16'($urandom);
        if (k == abort_k) begin
          do_abort();
          return;
        end
        if (k == rst_k) begin
          do_reset();
          return;
        end
        bus.start = mess && (k == 1);
        if (mess && k == 1) bus.tap_last = 4'd7;
        rdy = ($urandom_range(99) >= stall_pct);
        bus.coef_ready = rdy;
        @(posedge clk); #1;
        e++;
        if (rdy) begin
          if (k == int'(tl)) fin = 1'b1;
          else begin
            k++;
            fetch = 1'b1;
          end
        end else begin
          stalls++;
        end
      end
    end
    bus.start      = 1'b0;
    bus.coef_ready = 1'b0;
    chk("sweep_finished", 32'(fin), 32'(1));
    chk("done_pulse", 32'(bus.done), 32'(1));
    chk("done_busy", 32'(bus.busy), 32'(0));
    chk("done_valid", 32'(bus.coef_valid), 32'(0));
    chk("done_last", 32'(bus.coef_last), 32'(0));
    chk("done_sel", 32'(bus.sel), 32'(0));
    chk("done_edge", 32'(e), 32'(2 * (int'(tl) + 1) + stalls));
    if (chain) begin
      bus.start    = 1'b1;
      bus.tap_last = chain_tl;
    end else begin
      @(posedge clk); #1;
      chk("done_width", 32'(bus.done), 32'(0));
      chk("idle_busy", 32'(bus.busy), 32'(0));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.tap_last   = '0;
    bus.coef_ready = 1'b0;
    base           = 16'hA000;
    junk           = '0;
    junk_en        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(bus.sel), 32'(0));
    chk("rst_coef", 32'(bus.coef_out), 32'(0));
    chk("rst_valid", 32'(bus.coef_valid), 32'(0));
    chk("rst_last", 32'(bus.coef_last), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    rst_n = 1'b1;
    idle_checks("idle", 2);

    // Full 16-tap sweep without backpressure, then single tap.
    sweep(4'd15, 16'hA000, 0, -1, -1, 1'b0, 1'b0, 4'd0, 1'b0);
    sweep(4'd0, 16'hA000, 0, -1, -1, 1'b0, 1'b0, 4'd0, 1'b0);

    // Backpressure, then abort at tap 2 followed by a fresh sweep.
    sweep(4'd3, 16'hA000, 45, -1, -1, 1'b0, 1'b0, 4'd0, 1'b0);
    sweep(4'd5, 16'hA000, 20, 2, -1, 1'b0, 1'b0, 4'd0, 1'b0);
    sweep(4'd4, 16'h5A50, 0, -1, -1, 1'b0, 1'b0, 4'd0, 1'b0);

    // START/TAP_LAST disturbance mid-sweep, then back-to-back START at DONE.
    sweep(4'd3, 16'hA000, 30, -1, -1, 1'b1, 1'b1, 4'd7, 1'b0);
    sweep(4'd7, 16'h1230, 25, -1, -1, 1'b0, 1'b0, 4'd0, 1'b1);

    // Reset mid-sweep at tap 5, then recovery.
    sweep(4'd9, 16'hA000, 0, -1, 5, 1'b0, 1'b0, 4'd0, 1'b0);
    sweep(4'd2, 16'hBEE0, 10, -1, -1, 1'b0, 1'b0, 4'd0, 1'b0);

    // ABORT beats START in IDLE.
    bus.abort    = 1'b1;
    bus.start    = 1'b1;
    bus.tap_last = 4'd2;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("idle_abort_busy", 32'(bus.busy), 32'(0));
    chk("idle_abort_valid", 32'(bus.coef_valid), 32'(0));
    idle_checks("idle_abort", 2);

    for (int i = 0; i < 8; i++)
      sweep(4'($urandom_range(15)), 16'($urandom), int'($urandom_range(60)),
            -1, -1, 1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
